// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one uart_tx between NREQ requesters; latches the winner's byte/config, pulses tx_start, waits for tx_done.
// Latency: req seen at edge k gives gnt/tx_start during cycle k+1; at least 2 cycles from done to the next tx_start.
// Backpressure: requesters hold req (with stable data/cfg) until gnt; one frame in flight; WAIT is bounded by TIMEOUT cycles.
// Build option: define UART_TX_ARB_FIXED_PRI_EN for fixed priority (lowest index wins); default is round-robin.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              tx_clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [7*NREQ-1:0] req_cfg,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [3:0]        length,
  output logic              parity_type,
  output logic              parity_en,
  output logic              stop2,
  input  logic              tx_done
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_REJECT = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic [PW-1:0]   cur, cur_nxt;
  logic [15:0]     cnt, cnt_nxt;

  // next values of the registered outputs
  logic [NREQ-1:0] gnt_nxt, done_nxt, err_nxt;
  logic            busy_nxt, tx_start_nxt;
  logic [7:0]      tx_data_nxt;
  logic [3:0]      length_nxt;
  logic            parity_type_nxt, parity_en_nxt, stop2_nxt;

  // arbitration result
  logic            win_found;
  logic [PW-1:0]   win_idx;
  logic [7:0]      win_data;
  logic [6:0]      win_cfg;
  logic            win_len_ok;
  logic [NREQ-1:0] win_oh, cur_oh;
  int              scan_k;

  // Search for the first set request at or after the search base, wrapping downward to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_k    = 0;
    for (int i = 0; i < NREQ; i++) begin
`ifdef UART_TX_ARB_FIXED_PRI_EN
      scan_k = i;
`else
      scan_k = int'(ptr) + i;
      if (scan_k >= NREQ) scan_k = scan_k - NREQ;
`endif
      if (!win_found && req[scan_k]) begin
        win_found = 1'b1;
        win_idx   = PW'(scan_k);
      end
    end
  end

  assign win_data   = req_data[8*int'(win_idx) +: 8];
  assign win_cfg    = req_cfg[7*int'(win_idx) +: 7];
  assign win_len_ok = (win_cfg[6:3] >= 4'd5) && (win_cfg[6:3] <= 4'd8);
  assign win_oh     = NREQ'(1) << win_idx;
  assign cur_oh     = NREQ'(1) << cur;

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    cur_nxt         = cur;
    cnt_nxt         = cnt;
    gnt_nxt         = '0;
    done_nxt        = '0;
    err_nxt         = '0;
    tx_start_nxt    = 1'b0;
    tx_data_nxt     = tx_data;
    length_nxt      = length;
    parity_type_nxt = parity_type;
    parity_en_nxt   = parity_en;
    stop2_nxt       = stop2;
    case (state)
      S_IDLE: begin
        if (win_found) begin
          cur_nxt = win_idx;
`ifndef UART_TX_ARB_FIXED_PRI_EN
          if (int'(win_idx) == NREQ - 1) ptr_nxt = '0;
          else                          ptr_nxt = win_idx + 1'b1;
`endif
          gnt_nxt = win_oh;
          if (win_len_ok) begin
            state_nxt       = S_START;
            tx_start_nxt    = 1'b1;
            tx_data_nxt     = win_data;
            length_nxt      = win_cfg[6:3];
            parity_type_nxt = win_cfg[2];
            parity_en_nxt   = win_cfg[1];
            stop2_nxt       = win_cfg[0];
          end else begin
            // bad length: acknowledge and flag, uart-side outputs keep their old values
            state_nxt = S_REJECT;
            err_nxt   = win_oh;
          end
        end
      end
      S_START: begin
        state_nxt = S_WAIT;
        cnt_nxt   = '0;
      end
      S_WAIT: begin
        // tx_done takes precedence over a timeout in the same cycle
        if (tx_done) begin
          state_nxt = S_DONE;
          done_nxt  = cur_oh;
        end else if (cnt == 16'(TIMEOUT - 1)) begin
          state_nxt = S_DONE;
          err_nxt   = cur_oh;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_DONE:   state_nxt = S_IDLE;
      S_REJECT: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State, pointer, counter and output registers with synchronous reset.
  always_ff @(posedge tx_clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      cur         <= '0;
      cnt         <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= '0;
      busy        <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= '0;
      length      <= '0;
      parity_type <= 1'b0;
      parity_en   <= 1'b0;
      stop2       <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      cur         <= cur_nxt;
      cnt         <= cnt_nxt;
      gnt         <= gnt_nxt;
      done        <= done_nxt;
      err         <= err_nxt;
      busy        <= busy_nxt;
      tx_start    <= tx_start_nxt;
      tx_data     <= tx_data_nxt;
      length      <= length_nxt;
      parity_type <= parity_type_nxt;
      parity_en   <= parity_en_nxt;
      stop2       <= stop2_nxt;
    end
  end

endmodule
